// File: rtl/io_rle_loader.sv
// Run-length-decoding record loader: unpacks RLE words into a bit buffer, slices ELEM_W-bit
// elements and routes header-described records onto per-channel auto-incrementing RAM write ports.
module io_rle_loader #(
    parameter int WORD_W = 32,
    parameter int RUN_W  = 3,
    parameter int ELEM_W = 16,
    parameter int NCH    = 4,
    parameter int RAM_W  = 64,
    parameter int ADDR_W = 16,
    parameter int BUF_W  = 72
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic [NCH-1:0]    wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [RAM_W-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       elem_cnt
);
    localparam int G      = WORD_W / (RUN_W + 1);
    localparam int MAXRUN = G * ((1 << RUN_W) - 1);
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W  = ELEM_W - CH_W - 1;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int ADD_W  = $clog2(MAXRUN + 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

    state_t            state, state_n;
    logic [BUF_W-1:0]  bit_buf, bit_buf_n;
    logic [FILL_W-1:0] fill, fill_n;
    logic [CH_W-1:0]   chan, chan_n;
    logic              sext, sext_n;
    logic [CNT_W-1:0]  remain, remain_n;
    logic [ADDR_W-1:0] ptr   [NCH];
    logic [ADDR_W-1:0] ptr_n [NCH];
    logic [NCH-1:0]    wr_en_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [RAM_W-1:0]  wr_data_n;
    logic              err_n;
    logic [31:0]       elem_cnt_n;

    logic [MAXRUN-1:0] dec_bits;
    logic [ADD_W-1:0]  dec_len;
    logic [RUN_W-1:0]  run;
    logic              accept;
    logic              extract;
    logic [ELEM_W-1:0] elem;
    logic [RAM_W-1:0]  elem_ext;

    assign busy     = (state == HDR) || (state == DATA);
    assign done     = (state == DONE);
    assign in_ready = busy && (fill <= FILL_W'(BUF_W - MAXRUN));
    assign accept   = in_valid && in_ready;
    assign extract  = busy && (fill >= FILL_W'(ELEM_W));
    // Newest bit sits at bit 0, so the oldest ELEM_W bits end at position fill-1.
    assign elem     = ELEM_W'(bit_buf >> (fill - FILL_W'(ELEM_W)));

    always_comb begin
        dec_bits = '0;
        dec_len  = '0;
        run      = '0;
        for (int g = 0; g < G; g++) begin
            run      = in_data[WORD_W-2-g*(RUN_W+1) -: RUN_W];
            dec_bits = dec_bits << run;
            if (in_data[WORD_W-1-g*(RUN_W+1)])
                dec_bits = dec_bits | ((MAXRUN'(1) << run) - MAXRUN'(1));
            dec_len  = dec_len + ADD_W'(run);
        end
    end

    always_comb begin
        elem_ext               = '0;
        elem_ext[ELEM_W-1:0]   = elem;
        if (sext) begin
            for (int i = ELEM_W; i < RAM_W; i++)
                elem_ext[i] = elem[ELEM_W-1];
        end
    end

    always_comb begin
        state_n    = state;
        bit_buf_n  = bit_buf;
        chan_n     = chan;
        sext_n     = sext;
        remain_n   = remain;
        ptr_n      = ptr;
        wr_en_n    = '0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        err_n      = err;
        elem_cnt_n = elem_cnt;

        if (accept)
            bit_buf_n = (bit_buf << dec_len) | BUF_W'(dec_bits);
        fill_n = fill + (accept ? FILL_W'(dec_len) : '0) - (extract ? FILL_W'(ELEM_W) : '0);

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n    = HDR;
                    bit_buf_n  = '0;
                    fill_n     = '0;
                    err_n      = 1'b0;
                    elem_cnt_n = '0;
                    for (int i = 0; i < NCH; i++)
                        ptr_n[i] = '0;
                end
            end
            HDR: begin
                if (extract) begin
                    if (elem[CNT_W-1:0] == '0) begin
                        // Terminator: whatever is left in the buffer is padding.
                        state_n = DONE;
                        fill_n  = '0;
                    end else begin
                        state_n  = DATA;
                        chan_n   = elem[ELEM_W-1 -: CH_W];
                        sext_n   = elem[ELEM_W-1-CH_W];
                        remain_n = elem[CNT_W-1:0];
                    end
                end
            end
            DATA: begin
                if (extract) begin
                    elem_cnt_n = elem_cnt + 32'd1;
                    if (int'(chan) < NCH) begin
                        wr_en_n     = NCH'(1) << chan;
                        wr_addr_n   = ptr[chan];
                        wr_data_n   = elem_ext;
                        ptr_n[chan] = ptr[chan] + ADDR_W'(1);
                    end else begin
                        err_n = 1'b1;
                    end
                    remain_n = remain - CNT_W'(1);
                    if (remain == CNT_W'(1))
                        state_n = HDR;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_buf  <= '0;
            fill     <= '0;
            chan     <= '0;
            sext     <= 1'b0;
            remain   <= '0;
            wr_en    <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            err      <= 1'b0;
            elem_cnt <= '0;
            for (int i = 0; i < NCH; i++)
                ptr[i] <= '0;
        end else begin
            state    <= state_n;
            bit_buf  <= bit_buf_n;
            fill     <= fill_n;
            chan     <= chan_n;
            sext     <= sext_n;
            remain   <= remain_n;
            wr_en    <= wr_en_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            err      <= err_n;
            elem_cnt <= elem_cnt_n;
            ptr      <= ptr_n;
        end
    end
endmodule

// File: doc/io_rle_loader.md
Name: io_rle_loader

Overview:
- Parametrised successor of the host IO loader. Accepts run-length-encoded input words through a valid/ready handshake and unpacks them into a bit buffer.
- Splits the decoded bit stream into fixed-width elements. Each run of elements is preceded by a header element that routes it to one of NCH RAM write channels, each with its own auto-incrementing address pointer.
- Sits between the host data bus and the per-matrix RAMs. Replaces the hard-coded field sequencing with a self-describing record stream.

Parameters:
- WORD_W, 32: input word width; must be a multiple of (RUN_W+1).
- RUN_W, 3: run-length field width per group.
- ELEM_W, 16: decoded element width.
- NCH, 4: number of RAM write channels.
- RAM_W, 64: RAM data width; must be ≥ ELEM_W.
- ADDR_W, 16: per-channel address width.
- BUF_W, 72: bit-buffer capacity; must be ≥ ELEM_W-1+MAXRUN.
- Derived localparams:
  - G = WORD_W/(RUN_W+1)
  - MAXRUN = G*(2^RUN_W-1), which is 56 at the defaults
  - CH_W = max(1, clog2(NCH))

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- start  in  1  pulse; begins a new stream
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  WORD_W  RLE word
- wr_en  out  NCH  one-hot channel write strobe
- wr_addr  out  ADDR_W  write address of the strobed channel
- wr_data  out  RAM_W  element, zero- or sign-extended to RAM_W
- busy  out  1  state is HDR or DATA
- done  out  1  stream terminated; held until the next start
- err  out  1  sticky; a header selected channel ≥ NCH
- elem_cnt  out  32  data elements consumed since start

Behaviour:
- Reset: every output is 0 on the clock edge where rst=1:
  - wr_en, wr_addr, wr_data, in_ready, busy, done, err, elem_cnt all 0
  - buffer fill = 0, all channel pointers = 0, state = IDLE
- Reset mid-stream discards the buffer and the record in progress. No write is issued in the reset cycle.
- States:
  - IDLE: start → HDR. On the start edge, clear fill, pointers, err and elem_cnt.
  - HDR: extract one element as the header.
    - count=0 → DONE.
    - count≠0 → DATA, latching channel, sext flag and remaining=count.
  - DATA: each extracted element decrements remaining; remaining reaching 0 → HDR.
  - DONE: done=1 and in_ready=0. Leftover buffer bits are discarded. start → HDR, with the same clearing as from IDLE.
- start in HDR or DATA is ignored.
- RLE decode:
  - in_data splits into G groups, most-significant group first.
  - Each group is [value bit | RUN_W-bit run]. It appends `run` copies of the value bit, so run=0 appends nothing.
  - A whole word is decoded in the cycle it is accepted (in_valid & in_ready).
- in_ready = busy && (fill ≤ BUF_W-MAXRUN), using fill at the start of the cycle.
- Extraction:
  - When busy and fill ≥ ELEM_W, the oldest ELEM_W bits form one element per cycle. The first decoded bit becomes the element MSB.
  - Accepting a word and extracting an element in the same cycle is allowed. The new fill is fill + appended − ELEM_W.
- Header layout:
  - [ELEM_W-1 -: CH_W] = channel
  - next bit = sext
  - remaining low bits = count, unsigned
- Data write (registered):
  - When the element is extracted on edge k, outputs are valid after edge k:
    - wr_en = one-hot(channel) for exactly one cycle
    - wr_addr = ptr[channel]
    - wr_data = element, sign-extended if sext else zero-extended
  - ptr[channel] then increments, wrapping modulo 2^ADDR_W with no flag.
  - elem_cnt increments.
- Channel ≥ NCH: elements are consumed and counted, but wr_en stays 0 and err is set.
- Latency: a word accepted on edge k can produce its first write strobe visible after edge k+1, and never earlier.
- wr_en is 0 in every cycle without an extraction in DATA. Header cycles never write.

Test Plan:
- Reset check: assert rst for 2 cycles with in_valid=1 and start=1 → all outputs 0, in_ready=0, state IDLE.
- Single record on ch1:
  - Stream: header 0x4002, elements 0x8001 and 0x0003, terminator header 0x0000, fed as RLE words.
  - Expect wr_en=4'b0010 with addr 0 / data 0x0000_0000_0000_8001, then addr 1 / data 0x3.
  - Then done=1, busy=0, elem_cnt=2.
- Sign extension: header 0xA001 (ch2, sext, count 1) with element 0x8001 → wr_en=4'b0100, wr_data=0xFFFF_FFFF_FFFF_8001.
- Backpressure:
  - After start, hold in_valid=1 with in_data=0xFFFFFFFF (56 ones per word).
  - in_ready drops whenever fill > 16.
  - No word is lost or duplicated: the total of 1s written equals 56 × words accepted, minus header bits.
- Zero runs: words 0x00000000 are accepted every cycle, add no bits and produce no writes. A following real word still decodes correctly.
- Corner cases:
  - Header 0xC001 with NCH=3 → no write, err=1, elem_cnt=1.
  - With ADDR_W=2, write 5 elements to ch0 → addresses 0,1,2,3,0.
  - Pulse rst in mid-record, then restart → the addresses of the first record restart from 0.
